vga_sync_gen: RTL

//  Timing source for the VGA pattern blocks. Generates h/v counters, pix_x/pix_y,

---
 rtl/vga_sync_gen.sv | 97 +++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing counters, active-area decode and registered TinyVGA PMOD byte.
// Latency 1 clk from pix_x/pix_y + rgb_in to uo_out; no handshake, ena=0 freezes all state.
module vga_sync_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   FRAME_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [5:0]         rgb_in,
  output logic [9:0]         pix_x,
  output logic [9:0]         pix_y,
  output logic               video_active,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [7:0]         uo_out
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_S = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_E = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_S = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_E = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must fit the 10-bit counters");
    end
  endgenerate

  logic [9:0]         r_x;
  logic [9:0]         r_y;
  logic [FRAME_W-1:0] r_frame;
  logic [7:0]         r_uo;

  logic       w_x_last;
  logic       w_y_last;
  logic       w_active;
  logic       w_hs;
  logic       w_vs;
  logic [5:0] w_rgb;

  assign w_x_last = (r_x == H_LAST);
  assign w_y_last = (r_y == V_LAST);
  assign w_active = (r_x < H_VIS) && (r_y < V_VIS);

  // vsync depends on the line only, so it spans whole lines including their h-blanking
  assign w_hs  = ((r_x >= H_SYNC_S) && (r_x < H_SYNC_E)) ? HSYNC_POL : ~HSYNC_POL;
  assign w_vs  = ((r_y >= V_SYNC_S) && (r_y < V_SYNC_E)) ? VSYNC_POL : ~VSYNC_POL;
  assign w_rgb = w_active ? rgb_in : 6'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_frame <= '0;
      r_uo    <= {~HSYNC_POL, 3'b000, ~VSYNC_POL, 3'b000};
    end else if (ena) begin
      if (w_x_last) begin
        r_x <= '0;
        if (w_y_last) begin
          r_y     <= '0;
          r_frame <= r_frame + FRAME_W'(1);
        end else begin
          r_y <= r_y + 10'd1;
        end
      end else begin
        r_x <= r_x + 10'd1;
      end
      // PMOD order {hs,B0,G0,R0,vs,B1,G1,R1}; rgb_in is {R1,R0,G1,G0,B1,B0}
      r_uo <= {w_hs, w_rgb[0], w_rgb[2], w_rgb[4], w_vs, w_rgb[1], w_rgb[3], w_rgb[5]};
    end
  end

  assign pix_x        = r_x;
  assign pix_y        = r_y;
  assign video_active = w_active;
  assign frame_start  = (r_x == 10'd0) && (r_y == 10'd0);
  assign frame_cnt    = r_frame;
  assign uo_out       = r_uo;

endmodule
